instr_fetch: RTL

- Instruction fetch stage directly upstream of the decoder. Generates the PC stream and requests instruction words from instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned words with their PCs in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts a redirect from execute (taken branch, JAL, JALR). On redirect it flushes the buffer and discards in-flight stale responses.

---
 rtl/instr_fetch.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: PC generator, imem request/response tracker and small
// instruction FIFO in front of decode. Redirects flush and drop stale words.
// Ports: clk, rst_n (sync, active low); imem_req_valid/ready/addr request
// channel; imem_rsp_valid/data in-order responses; redirect_valid/pc from
// execute; out_valid/ready/instr/pc towards decode.
// Build option FETCH_MISALIGN_CHK_EN: adds out_misalign; a misaligned
// redirect enqueues one NOP entry flagged misaligned and halts fetch until
// the next redirect. Without it the redirect target is aligned down.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc
`ifdef FETCH_MISALIGN_CHK_EN
   ,
   output logic        out_misalign
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   fetch_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop;
   logic [CW-1:0] count;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] pq_wr;
   logic [AW-1:0] pq_rd;
   logic          halt;

   logic [31:0] f_instr [DEPTH];
   logic [31:0] f_pc    [DEPTH];
   logic [31:0] pcq     [DEPTH];

   logic          redir_mis;
   logic [31:0]   redir_tgt;
   logic [CW:0]   inflight;
   logic [CW-1:0] out_after;
   logic          req_fire;
   logic          pop_raw;
   logic          do_pop;
   logic          rsp_take;

`ifdef FETCH_MISALIGN_CHK_EN
   logic f_mis [DEPTH];
   assign redir_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign redir_tgt = redirect_pc;
`else
   assign redir_mis = 1'b0;
   assign redir_tgt = {redirect_pc[31:2], 2'b00};
`endif

   assign out_valid = (count != '0);
   assign pop_raw   = out_valid && out_ready;

   // A slot freed by this cycle's pop is already reusable, which keeps
   // one request per cycle flowing with DEPTH=2 and zero-wait memory.
   assign inflight = {1'b0, outstanding} + {1'b0, count}
                   - {{CW{1'b0}}, pop_raw};

   assign imem_req_valid = rst_n && !redirect_valid && !halt
                        && (inflight < (CW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc;

   assign req_fire  = imem_req_valid && imem_req_ready;
   assign do_pop    = pop_raw && !redirect_valid;
   assign rsp_take  = imem_rsp_valid && (drop == '0) && !redirect_valid;
   assign out_after = outstanding - {{(CW-1){1'b0}}, imem_rsp_valid};

   assign out_instr = out_valid ? f_instr[rd_ptr] : '0;
   assign out_pc    = out_valid ? f_pc[rd_ptr]    : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         pq_wr       <= '0;
         pq_rd       <= '0;
         halt        <= 1'b0;
      end else if (redirect_valid) begin
         // Everything still in flight after this cycle is stale.
         fetch_pc    <= redir_tgt;
         outstanding <= out_after;
         drop        <= out_after;
         rd_ptr      <= '0;
         pq_wr       <= '0;
         pq_rd       <= '0;
         wr_ptr      <= redir_mis ? AW'(1) : '0;
         count       <= redir_mis ? CW'(1) : '0;
         halt        <= redir_mis;
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
            pq_wr    <= pq_wr + AW'(1);
         end
         outstanding <= out_after + {{(CW-1){1'b0}}, req_fire};
         if (imem_rsp_valid && (drop != '0))
            drop <= drop - CW'(1);
         if (rsp_take) begin
            wr_ptr <= wr_ptr + AW'(1);
            pq_rd  <= pq_rd + AW'(1);
         end
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count
                + {{(CW-1){1'b0}}, rsp_take}
                - {{(CW-1){1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && redir_mis) begin
         f_instr[0] <= NOP;
         f_pc[0]    <= redirect_pc;
      end else if (rst_n && rsp_take) begin
         f_instr[wr_ptr] <= imem_rsp_data;
         f_pc[wr_ptr]    <= pcq[pq_rd];
      end
      if (req_fire)
         pcq[pq_wr] <= fetch_pc;
   end

`ifdef FETCH_MISALIGN_CHK_EN
   always_ff @(posedge clk) begin
      if (rst_n && redir_mis)
         f_mis[0] <= 1'b1;
      else if (rst_n && rsp_take)
         f_mis[wr_ptr] <= 1'b0;
   end
   assign out_misalign = out_valid && f_mis[rd_ptr];
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n && imem_rsp_valid)
         assert (outstanding != '0)
         else $error("imem response with nothing outstanding");
   end
`endif

endmodule
